// File: rtl/fft_reorder_buf_pkg.sv
// Shared types and helpers for the FFT output reorder stage (package fft_pkg).
// Bank-state encoding, default complex widths and a generic bit-reversal.
package fft_pkg;

  localparam int MAX_LOG2N  = 10;
  localparam int CPLX_IN_W  = 24;
  localparam int CPLX_OUT_W = 16;
  localparam int CPLX_FRAC  = 8;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  // Reverses the low nbits of k; bits at and above nbits come back as zero.
  function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] k,
                                                  input int nbits);
    logic [MAX_LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LOG2N; i++) begin
      if (i < nbits) r[i] = k[nbits-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_buf_if.sv
// Sample stream interface of the FFT reorder buffer: bit-reversed input side,
// natural-order output side and the frame-discard pulse.
interface fft_reorder_buf_if #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 16
);
  // Input side has no ready: a sample is taken on every cycle in_valid is high.
  // Output side: a word transfers on a clock edge where out_valid && out_ready;
  // while out_valid && !out_ready the word and out_last stay stable.
  logic                    in_valid;
  logic                    in_sof;
  logic signed [IN_W-1:0]  in_r;
  logic signed [IN_W-1:0]  in_i;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_r;
  logic signed [OUT_W-1:0] out_i;
  logic                    out_last;
  logic                    ovf;

  modport master (
    output in_valid, in_sof, in_r, in_i, out_ready,
    input  out_valid, out_r, out_i, out_last, ovf
  );

  modport slave (
    input  in_valid, in_sof, in_r, in_i, out_ready,
    output out_valid, out_r, out_i, out_last, ovf
  );
endinterface

// File: rtl/fft_reorder_scale.sv
// Combinational IN_W -> OUT_W scaling of one signed component.
// FFT_REORDER_RND_EN selects round-half-up with saturation; otherwise plain truncation.
module fft_reorder_scale #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 16,
  parameter int FRAC  = 8
) (
  input  logic signed [IN_W-1:0]  x,
  output logic signed [OUT_W-1:0] y
);

`ifdef FFT_REORDER_RND_EN
  localparam logic [IN_W:0] HALF_U = {{IN_W{1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic signed [IN_W:0] MAX_V = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_V = {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W:0] sum;
  logic signed [IN_W:0] shifted;

  // One guard bit keeps the rounding add from wrapping at the positive limit.
  assign sum     = $signed({x[IN_W-1], x}) + $signed(HALF_U);
  assign shifted = sum >>> FRAC;

  always_comb begin
    y = shifted[OUT_W-1:0];
    if (shifted > MAX_V)      y = MAX_V[OUT_W-1:0];
    else if (shifted < MIN_V) y = MIN_V[OUT_W-1:0];
  end
`else
  logic unused_trunc_bits;

  assign y = x[FRAC+OUT_W-1:FRAC];
  assign unused_trunc_bits = ^x;
`endif

endmodule

// File: rtl/fft_reorder_buf.sv
// Ping-pong reorder buffer: writes bit-reversed FFT output into one of two banks
// and streams full banks in natural order. Optional rounding via FFT_REORDER_RND_EN.
module fft_reorder_buf
  import fft_pkg::*;
#(
  parameter int LOG2N = 5,
  parameter int IN_W  = CPLX_IN_W,
  parameter int OUT_W = CPLX_OUT_W,
  parameter int FRAC  = CPLX_FRAC
) (
  input  logic                clk,
  input  logic                reset,
  fft_reorder_buf_if.slave    bus,
  output bank_state_t [1:0]   dbg_bank_state
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST_IDX = {LOG2N{1'b1}};

  bank_state_t [1:0] bank_q, bank_d;

  logic             wr_bank, rd_bank, drop_q;
  logic [LOG2N-1:0] wr_cnt, rd_cnt;

  logic             frame_start, bank_open, drop_now, wr_en, wr_last;
  logic [LOG2N-1:0] cnt_now, wr_addr;
  logic [MAX_LOG2N-1:0] rev_wide;
  logic             unused_rev_bits;

  logic signed [OUT_W-1:0] sc_r, sc_i;
  logic [2*OUT_W-1:0]      mem [2*N];
  logic [2*OUT_W-1:0]      rd_word;

  logic                    rd_avail, rd_load, rd_last;
  logic                    out_valid_q, out_last_q;
  logic signed [OUT_W-1:0] out_r_q, out_i_q;

  fft_reorder_scale #(.IN_W(IN_W), .OUT_W(OUT_W), .FRAC(FRAC)) u_scale_r (
    .x (bus.in_r),
    .y (sc_r)
  );

  fft_reorder_scale #(.IN_W(IN_W), .OUT_W(OUT_W), .FRAC(FRAC)) u_scale_i (
    .x (bus.in_i),
    .y (sc_i)
  );

  // Write decode: the drop decision is taken at frame start against the
  // registered bank state and then held for the rest of the frame.
  always_comb begin
    frame_start = bus.in_valid && ((wr_cnt == '0) || bus.in_sof);
    bank_open   = (bank_q[wr_bank] == BANK_EMPTY) || (bank_q[wr_bank] == BANK_FILLING);
    drop_now    = frame_start ? !bank_open : drop_q;
    cnt_now     = (bus.in_valid && bus.in_sof) ? '0 : wr_cnt;
    wr_en       = bus.in_valid && !drop_now;
    wr_last     = wr_en && (cnt_now == LAST_IDX);
  end

  assign rev_wide        = bitrev(MAX_LOG2N'(cnt_now), LOG2N);
  assign wr_addr         = rev_wide[LOG2N-1:0];
  assign unused_rev_bits = ^rev_wide;

  assign rd_word  = mem[{rd_bank, rd_cnt}];
  assign rd_avail = (bank_q[rd_bank] == BANK_FULL) || (bank_q[rd_bank] == BANK_DRAINING);
  assign rd_load  = rd_avail && (!out_valid_q || bus.out_ready);
  assign rd_last  = rd_load && (rd_cnt == LAST_IDX);

  // Writer and reader never own the same bank at once, so their updates cannot collide.
  always_comb begin
    bank_d = bank_q;
    if (wr_en && frame_start) bank_d[wr_bank] = BANK_FILLING;
    if (wr_last)              bank_d[wr_bank] = BANK_FULL;
    if (rd_load)              bank_d[rd_bank] = rd_last ? BANK_EMPTY : BANK_DRAINING;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_q[0] <= BANK_EMPTY;
      bank_q[1] <= BANK_EMPTY;
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      drop_q    <= 1'b0;
    end else begin
      bank_q <= bank_d;
      if (bus.in_valid) begin
        wr_cnt <= cnt_now + LOG2N'(1);
        drop_q <= drop_now;
        if (wr_last) wr_bank <= ~wr_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= {sc_r, sc_i};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_bank     <= 1'b0;
      rd_cnt      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
    end else if (rd_load) begin
      out_valid_q <= 1'b1;
      out_last_q  <= (rd_cnt == LAST_IDX);
      out_r_q     <= $signed(rd_word[2*OUT_W-1:OUT_W]);
      out_i_q     <= $signed(rd_word[OUT_W-1:0]);
      rd_cnt      <= rd_cnt + LOG2N'(1);
      if (rd_cnt == LAST_IDX) rd_bank <= ~rd_bank;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_last    = out_last_q;
  assign bus.out_r       = out_r_q;
  assign bus.out_i       = out_i_q;
  assign bus.ovf         = frame_start && !bank_open;
  assign dbg_bank_state  = bank_q;

endmodule

// File: tb/tb_fft_reorder_buf.sv
// Self-checking bench for fft_reorder_buf (N=32, 24->16 bits, FRAC=8).
// Scaling expectations follow FFT_REORDER_RND_EN when it is defined.
module tb_fft_reorder_buf;
  import fft_pkg::*;

  localparam int LOG2N = 5;
  localparam int N     = 32;
  localparam int IN_W  = 24;
  localparam int OUT_W = 16;
  localparam int FRAC  = 8;
  localparam int W     = 2*OUT_W + 1;

  typedef struct {
    logic [IN_W-1:0]  din;
    logic [OUT_W-1:0] dexp;
  } scale_vec_t;

  logic clk = 1'b0;
  logic reset;
  bank_state_t [1:0] dbg_bank_state;

  always #5 clk = ~clk;

  fft_reorder_buf_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  fft_reorder_buf #(.LOG2N(LOG2N), .IN_W(IN_W), .OUT_W(OUT_W), .FRAC(FRAC)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .dbg_bank_state (dbg_bank_state)
  );

  logic [W-1:0]    exp_q[$];
  logic [IN_W-1:0] frm_r [N];
  logic [IN_W-1:0] frm_i [N];
  scale_vec_t      sv [3];

  int   n_cmp, n_err, cyc, acc_cnt, first_acc, last_acc, ovf_cnt;
  logic exp_ovf, toggle_ready, hold_pend;
  logic [W-1:0] held_word;

  function automatic int brev(input int k);
    int r;
    r = 0;
    for (int i = 0; i < LOG2N; i++) if (k[i]) r |= (1 << (LOG2N-1-i));
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard / protocol monitor, sampled on the falling edge.
  task automatic monitor();
    logic [W-1:0] word, e;
    if (reset) begin
      hold_pend = 1'b0;
      return;
    end
    word = {bus.out_r, bus.out_i, bus.out_last};
    check("ovf", W'(bus.ovf), W'(exp_ovf));
    if (bus.ovf) ovf_cnt++;
    if (hold_pend) begin
      check("hold_valid", W'(bus.out_valid), W'(1));
      check("hold_word", word, held_word);
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got %h, expected no output (cycle %0d)", word, cyc);
      end else begin
        e = exp_q.pop_front();
        check("out_word", word, e);
      end
      if (acc_cnt == 0) first_acc = cyc;
      last_acc = cyc;
      acc_cnt++;
    end
    hold_pend = bus.out_valid && !bus.out_ready;
    held_word = word;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    if (toggle_ready) bus.out_ready = ~bus.out_ready;
  endtask

  task automatic build_frame(input int base);
    for (int n = 0; n < N; n++) begin
      frm_r[n] = IN_W'((base + n) << FRAC);
      frm_i[n] = IN_W'(-((base + n) << FRAC));
    end
  endtask

  task automatic push_frame(input int base);
    for (int n = 0; n < N; n++)
      exp_q.push_back({OUT_W'(base + n), OUT_W'(-(base + n)), (n == N-1)});
  endtask

  task automatic send_frame(input int len, input logic sof, input int drop_at);
    for (int k = 0; k < len; k++) begin
      bus.in_valid = 1'b1;
      bus.in_sof   = sof && (k == 0);
      bus.in_r     = frm_r[brev(k)];
      bus.in_i     = frm_i[brev(k)];
      exp_ovf      = (k == drop_at);
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    exp_ovf      = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int b;
    b = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && b < 400) begin
      step();
      b++;
    end
    check(name, W'(exp_q.size()), '0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; acc_cnt = 0; first_acc = 0; last_acc = 0; ovf_cnt = 0;
    exp_ovf = 1'b0; toggle_ready = 1'b0; hold_pend = 1'b0; held_word = '0;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_r = '0; bus.in_i = '0; bus.out_ready = 1'b0;

`ifdef FFT_REORDER_RND_EN
    sv[0] = '{24'h000180, 16'h0002};
    sv[1] = '{24'hFFFF80, 16'h0000};
    sv[2] = '{24'h7FFFFF, 16'h7FFF};
`else
    sv[0] = '{24'h000180, 16'h0001};
    sv[1] = '{24'hFFFF80, 16'hFFFF};
    sv[2] = '{24'h7FFFFF, 16'h7FFF};
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", W'(bus.out_valid), '0);
    check("rst_out_r", W'($unsigned(bus.out_r)), '0);
    check("rst_out_i", W'($unsigned(bus.out_i)), '0);
    check("rst_out_last", W'(bus.out_last), '0);
    check("rst_ovf", W'(bus.ovf), '0);
    check("rst_banks", W'(dbg_bank_state), '0);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    step();

    // Single frame: natural-order output and latency after the last input
    build_frame(0);
    push_frame(0);
    send_frame(N, 1'b1, -1);
    check("lat_valid_low", W'(bus.out_valid), '0);
    check("lat_bank0_full", W'(dbg_bank_state[0]), W'(BANK_FULL));
    step();
    check("lat_valid_high", W'(bus.out_valid), W'(1));
    check("lat_first_r", W'($unsigned(bus.out_r)), '0);
    wait_drain("drain_single");

    // Back-to-back frames with out_ready high
    acc_cnt = 0; ovf_cnt = 0;
    for (int f = 1; f <= 3; f++) begin
      build_frame(100*f);
      push_frame(100*f);
      send_frame(N, 1'b1, -1);
    end
    wait_drain("drain_b2b");
    check("b2b_count", W'(acc_cnt), W'(96));
    check("b2b_gapless", W'(last_acc - first_acc), W'(95));
    check("b2b_ovf", W'(ovf_cnt), '0);

    // Backpressure: third frame is dropped
    bus.out_ready = 1'b0;
    ovf_cnt = 0;
    build_frame(400); push_frame(400); send_frame(N, 1'b1, -1);
    build_frame(500); push_frame(500); send_frame(N, 1'b1, -1);
    build_frame(600); send_frame(N, 1'b1, 0);
    check("bp_ovf_once", W'(ovf_cnt), W'(1));
    check("bp_banks", W'(dbg_bank_state), W'({BANK_FULL, BANK_DRAINING}));
    bus.out_ready = 1'b1;
    wait_drain("drain_bp");

    // Stall hold with out_ready toggling every cycle
    toggle_ready = 1'b1;
    build_frame(700); push_frame(700); send_frame(N, 1'b1, -1);
    wait_drain("drain_stall");
    toggle_ready = 1'b0;
    bus.out_ready = 1'b1;

    // Resync: sof arrives at wr_cnt=10
    build_frame(800); send_frame(10, 1'b1, -1);
    build_frame(900); push_frame(900); send_frame(N, 1'b1, -1);
    wait_drain("drain_resync");

    // Scaling vectors placed at natural indices 0..2
    build_frame(1200);
    for (int j = 0; j < 3; j++) begin
      frm_r[j] = sv[j].din;
      frm_i[j] = sv[j].din;
    end
    for (int n = 0; n < N; n++) begin
      if (n < 3) exp_q.push_back({sv[n].dexp, sv[n].dexp, 1'b0});
      else       exp_q.push_back({OUT_W'(1200 + n), OUT_W'(-(1200 + n)), (n == N-1)});
    end
    send_frame(N, 1'b1, -1);
    wait_drain("drain_scale");

    // Reset in the middle of a drain
    build_frame(1000); push_frame(1000); send_frame(N, 1'b1, -1);
    repeat (10) step();
    reset = 1'b1;
    #1;
    check("rst_mid_valid", W'(bus.out_valid), '0);
    check("rst_mid_last", W'(bus.out_last), '0);
    check("rst_mid_banks", W'(dbg_bank_state), '0);
    exp_q.delete();
    step();
    step();
    reset = 1'b0;
    step();
    build_frame(1100); push_frame(1100); send_frame(N, 1'b1, -1);
    wait_drain("drain_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1);
  end

endmodule
